// File: rtl/fetch_sequencer.sv
// Instruction fetch and sequencing stage: owns the PC and the instruction register,
// fetches one-byte instructions over the shared memory bus and steps each one
// through FETCH, EXEC and, for lb/sb, a MEM access on the same bus.
module fetch_sequencer #(
  parameter int unsigned            ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [7:0]            mem_rdata,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_next,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [4:0]            opcode,
  output logic [2:0]            operand,
  output logic                  exec_en,
  output logic                  mem_done
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StMem} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [7:0]            ir_q;
  logic                  is_lb;
  logic                  is_sb;
  logic                  is_mem_op;

  // Local decode of the two bus-accessing opcodes (opcode[4:1] == IR[7:4]).
  always_comb begin
    is_lb     = (ir_q[7:4] == 4'b1001);
    is_sb     = (ir_q[7:4] == 4'b1010);
    is_mem_op = is_lb | is_sb;
  end

  // Sequencer state, PC and IR; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StFetch;
        StFetch: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + ADDR_WIDTH'(1);
            state_q <= StExec;
          end
        end
        StExec: begin
          if (is_mem_op) begin
            // pc_load is deliberately ignored for lb/sb.
            state_q <= StMem;
          end else begin
            if (pc_load) begin
              pc_q <= pc_next;
            end
            state_q <= StFetch;
          end
        end
        StMem: begin
          if (mem_ready) begin
            state_q <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore bus/strobe outputs decoded from state; mem_done also qualifies on mem_ready.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    exec_en  = 1'b0;
    mem_done = 1'b0;
    unique case (state_q)
      StIdle: ;
      StFetch: mem_req = 1'b1;
      StExec: exec_en = 1'b1;
      StMem: begin
        mem_req  = 1'b1;
        mem_we   = is_sb;
        mem_addr = data_addr;
        mem_done = mem_ready;
      end
      default: ;
    endcase
  end

  // IR fields and PC straight from registers.
  always_comb begin
    pc      = pc_q;
    opcode  = ir_q[7:3];
    operand = ir_q[2:0];
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: per-cycle vector table over a small
// program, plus a hand-written reset-during-MEM-wait sequence.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst_n;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic [7:0] data_addr;
  logic       pc_load;
  logic [7:0] pc_next;
  logic [7:0] pc;
  logic [4:0] opcode;
  logic [2:0] operand;
  logic       exec_en;
  logic       mem_done;

  logic       rdy;
  logic [7:0] mem [256];

  int n_chk;
  int n_fail;

  typedef struct packed {
    logic       rdy;
    logic       pl;
    logic [7:0] pn;
    logic [7:0] da;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic       ex;
    logic       done;
    logic [7:0] pc;
    logic [7:0] ir;
  } vec_t;

  vec_t vecs[$];

  fetch_sequencer #(
    .ADDR_WIDTH(8),
    .RESET_PC  (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .data_addr(data_addr),
    .pc_load  (pc_load),
    .pc_next  (pc_next),
    .pc       (pc),
    .opcode   (opcode),
    .operand  (operand),
    .exec_en  (exec_en),
    .mem_done (mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data only meaningful while ready.
  always_comb begin
    mem_ready = rdy;
    mem_rdata = rdy ? mem[mem_addr] : 8'hEE;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " exec_en"}, 32'(exec_en), 32'd0);
    chk({tag, " mem_done"}, 32'(mem_done), 32'd0);
    chk({tag, " pc"}, 32'(pc), 32'h00);
    chk({tag, " ir"}, 32'({opcode, operand}), 32'h00);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    rdy       = 1'b1;
    pc_load   = 1'b0;
    pc_next   = 8'h00;
    data_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h08;  // opcode 00001, operand 0
    mem[8'h01] = 8'hA0;  // sb
    mem[8'h02] = 8'h10;  // plain op, jumps to 0x7C
    mem[8'h7C] = 8'h93;  // lb, operand 3
    mem[8'h7D] = 8'h20;  // plain op, jumps to 0xFF
    mem[8'hFF] = 8'h18;  // plain op, PC wraps afterwards

    //               rdy  pl    pn     da     req  we   addr   ex   done pc     ir
    vecs.push_back({1'b1,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,8'h00}); // idle
    vecs.push_back({1'b1,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,8'h00}); // fetch 0
    vecs.push_back({1'b1,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,1'b1,1'b0,8'h01,8'h08}); // exec
    vecs.push_back({1'b1,1'b0,8'h00,8'h00,1'b1,1'b0,8'h01,1'b0,1'b0,8'h01,8'h08}); // fetch 1
    vecs.push_back({1'b1,1'b1,8'h55,8'h40,1'b0,1'b0,8'h00,1'b1,1'b0,8'h02,8'hA0}); // exec sb
    vecs.push_back({1'b1,1'b1,8'h55,8'h40,1'b1,1'b1,8'h40,1'b0,1'b1,8'h02,8'hA0}); // mem sb
    vecs.push_back({1'b1,1'b0,8'h00,8'h00,1'b1,1'b0,8'h02,1'b0,1'b0,8'h02,8'hA0}); // fetch 2
    vecs.push_back({1'b1,1'b1,8'h7C,8'h00,1'b0,1'b0,8'h00,1'b1,1'b0,8'h03,8'h10}); // exec jump
    vecs.push_back({1'b1,1'b0,8'h00,8'h00,1'b1,1'b0,8'h7C,1'b0,1'b0,8'h7C,8'h10}); // fetch 7C
    vecs.push_back({1'b1,1'b1,8'h11,8'h33,1'b0,1'b0,8'h00,1'b1,1'b0,8'h7D,8'h93}); // exec lb
    vecs.push_back({1'b0,1'b1,8'h11,8'h33,1'b1,1'b0,8'h33,1'b0,1'b0,8'h7D,8'h93}); // mem wait
    vecs.push_back({1'b1,1'b0,8'h00,8'h33,1'b1,1'b0,8'h33,1'b0,1'b1,8'h7D,8'h93}); // mem done
    vecs.push_back({1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h7D,1'b0,1'b0,8'h7D,8'h93}); // fetch wait
    vecs.push_back({1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h7D,1'b0,1'b0,8'h7D,8'h93}); // fetch wait
    vecs.push_back({1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h7D,1'b0,1'b0,8'h7D,8'h93}); // fetch wait
    vecs.push_back({1'b1,1'b0,8'h00,8'h00,1'b1,1'b0,8'h7D,1'b0,1'b0,8'h7D,8'h93}); // fetch ok
    vecs.push_back({1'b1,1'b1,8'hFF,8'h00,1'b0,1'b0,8'h00,1'b1,1'b0,8'h7E,8'h20}); // exec jump
    vecs.push_back({1'b1,1'b0,8'h00,8'h00,1'b1,1'b0,8'hFF,1'b0,1'b0,8'hFF,8'h20}); // fetch FF
    vecs.push_back({1'b1,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,8'h18}); // pc wrap
    vecs.push_back({1'b1,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,8'h18}); // fetch 0
    vecs.push_back({1'b1,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,1'b1,1'b0,8'h01,8'h08}); // exec

    // Reset held: outputs inactive.
    repeat (2) tick();
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      rdy       = vecs[i].rdy;
      pc_load   = vecs[i].pl;
      pc_next   = vecs[i].pn;
      data_addr = vecs[i].da;
      @(negedge clk);
      chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].req));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].we));
      if (vecs[i].req) chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d exec_en", i), 32'(exec_en), 32'(vecs[i].ex));
      chk($sformatf("v%0d mem_done", i), 32'(mem_done), 32'(vecs[i].done));
      chk($sformatf("v%0d pc", i), 32'(pc), 32'(vecs[i].pc));
      chk($sformatf("v%0d ir", i), 32'({opcode, operand}), 32'(vecs[i].ir));
      tick();
    end

    // Reset asserted while MEM waits on the bus for an sb.
    rdy       = 1'b1;
    pc_load   = 1'b0;
    data_addr = 8'h40;
    tick();  // FETCH at 0x01 completes
    tick();  // EXEC of sb
    rdy = 1'b0;
    #2;
    chk("pre-reset mem_req", 32'(mem_req), 32'd1);
    chk("pre-reset mem_we", 32'(mem_we), 32'd1);
    chk("pre-reset mem_addr", 32'(mem_addr), 32'h40);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async reset");
    tick();
    tick();
    rst_n = 1'b1;
    rdy   = 1'b1;
    @(negedge clk);
    chk("post-reset idle req", 32'(mem_req), 32'd0);
    tick();
    @(negedge clk);
    chk("post-reset fetch req", 32'(mem_req), 32'd1);
    chk("post-reset fetch addr", 32'(mem_addr), 32'h00);
    chk("post-reset ir", 32'({opcode, operand}), 32'h00);
    tick();
    @(negedge clk);
    chk("post-reset exec_en", 32'(exec_en), 32'd1);
    chk("post-reset opcode", 32'(opcode), 32'b00001);
    chk("post-reset pc", 32'(pc), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and sequencing stage of the 8-bit core, directly upstream of the `control` opcode decoder. Owns the PC and the instruction register (IR), fetches one-byte instructions over the shared memory bus, and presents `opcode`/`operand` to the decoder and datapath. Steps each instruction through FETCH, EXEC and, for `lb`/`sb`, a MEM access on the same bus. Issues the execute strobe that qualifies all datapath register writes.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, PC and memory address width.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  single core clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `mem_req`  out  1  bus request; address and write-enable are valid while high.
- `mem_we`  out  1  write access (`sb`); 0 for fetch and `lb`.
- `mem_addr`  out  ADDR_WIDTH  bus address.
- `mem_ready`  in  1  access completes in any cycle where `mem_req` && `mem_ready`.
- `mem_rdata`  in  8  read data, valid when `mem_ready` is high.
- `data_addr`  in  ADDR_WIDTH  `lb`/`sb` address from the accumulator.
- `pc_load`  in  1  jump/taken-branch request from the datapath, sampled only in EXEC.
- `pc_next`  in  ADDR_WIDTH  ALU-computed target, used when `pc_load` is sampled.
- `pc`  out  ADDR_WIDTH  current PC, registered.
- `opcode`  out  5  IR[7:3], feeds `control`.
- `operand`  out  3  IR[2:0], register select or 3-bit immediate.
- `exec_en`  out  1  one-cycle strobe while in EXEC.
- `mem_done`  out  1  MEM access completes this cycle; `lb` captures `mem_rdata`.

## Operation
- States: IDLE, FETCH, EXEC, MEM. Encoding is free.
- Reset (`rst_n` low, any time including mid-access): state IDLE, `pc`=RESET_PC, IR=0x00. All of `mem_req`, `mem_we`, `exec_en` and `mem_done` are 0. An in-flight access is abandoned without completing.
- IDLE: all outputs inactive. Goes unconditionally to FETCH on the next edge.
- FETCH:
  - Outputs: `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`.
  - On `mem_ready`: IR<=`mem_rdata`, `pc`<=`pc`+1 (mod 2^ADDR_WIDTH, so 0xFF wraps to 0x00), next state EXEC.
  - Without `mem_ready`: stay in FETCH, outputs held stable.
- EXEC:
  - `exec_en`=1, `mem_req`=0.
  - Memory op is decoded locally: opcode[4:1]=4'b1001 (`lb`) or 4'b1010 (`sb`).
  - Memory op: next state MEM; `pc_load` is ignored.
  - Otherwise: if `pc_load`, `pc`<=`pc_next`; next state FETCH.
  - `pc_next` is computed by the datapath against the already-incremented `pc`.
- MEM:
  - `mem_req`=1, `mem_addr`=`data_addr`, `mem_we`=1 for `sb` and 0 for `lb`.
  - On `mem_ready`: `mem_done`=1 (combinational, same cycle), next state FETCH.
  - Without `mem_ready`: hold. `pc_load` is ignored.
- Store write data is driven to memory by the datapath and is outside this block.
- `mem_ready` is ignored whenever `mem_req` is 0.
- `opcode` and `operand` are stable from EXEC entry until the next fetch completes.

## Timing
- `mem_req`, `mem_we`, `mem_addr`, `exec_en` and `mem_done` are Moore outputs of state. `mem_done` also depends on `mem_ready`. None is registered separately.
- With a zero-wait bus (`mem_ready` tied 1):
  - Non-memory instructions take 2 cycles (FETCH, EXEC).
  - `lb`/`sb` take 3 cycles (FETCH, EXEC, MEM).
- Each wait cycle on `mem_ready` adds exactly one cycle to FETCH or MEM.
- First fetch request appears in the second cycle after `rst_n` rises.
- `pc` update on fetch and on `pc_load` is visible the cycle after the triggering edge.

## Test plan
- Reset, zero-wait bus, memory[0]=0x08: `mem_req` first asserts with `mem_addr`=0x00 in the 2nd cycle after reset release. Next cycle: `opcode`=5'b00001, `operand`=0, `exec_en`=1, `pc`=0x01.
- Fetch with `mem_ready` held low for 3 cycles: `mem_addr` and `mem_we` stay stable throughout, IR unchanged, EXEC entered exactly 1 cycle after `mem_ready` rises.
- `sb` (0xA0) with `data_addr`=0x40: sequence FETCH, EXEC, MEM with `mem_addr`=0x40, `mem_we`=1, `mem_done`=1. `pc_load`=1 asserted during EXEC must not change `pc`.
- Jump: `pc_load`=1, `pc_next`=0x7C in EXEC → next fetch address 0x7C. Instruction at `pc`=0xFF fetched → `pc` wraps to 0x00.
- `rst_n` dropped mid-MEM wait: outputs go inactive immediately (asynchronous). After release, fetch resumes from RESET_PC with IR=0x00.
